// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard matrix arbiter and its scanner.
package kbd_pkg;

    localparam int KB_ROWS = 8;
    localparam int KB_COLS = 8;
    localparam int KB_KEYS = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SAMPLE,
        GAP
    } scan_state_t;

    function automatic logic [5:0] key_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/kbd_scan_seq.sv
// Autonomous matrix scanner: walks all keys into a shadow map and publishes
// the complete map at the end of each scan. Yields to the CPU at any time.
module kbd_scan_seq
    import kbd_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned SCAN_GAP = 1024
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               scan_en,
    input  logic               cpu_req,
    input  logic               kb_hit,
    output logic [2:0]         scan_row,
    output logic [2:0]         scan_col,
    output logic [KB_KEYS-1:0] key_map,
    output logic               map_valid,
    output logic               map_changed
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;

    scan_state_t       state;
    logic [SW-1:0]     settle_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [KB_KEYS-1:0] shadow;
    logic [KB_KEYS-1:0] new_map;

    always_comb begin
        new_map = shadow;
        new_map[key_idx(scan_row, scan_col)] = kb_hit;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            scan_row    <= '0;
            scan_col    <= '0;
            settle_cnt  <= '0;
            gap_cnt     <= '0;
            shadow      <= '0;
            key_map     <= '0;
            map_valid   <= 1'b0;
            map_changed <= 1'b0;
        end else begin
            map_valid   <= 1'b0;
            map_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en && !cpu_req) begin
                        state      <= SETUP;
                        scan_row   <= '0;
                        scan_col   <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETUP: begin
                    // A CPU access holds the count at zero so the position gets a full settle afterwards.
                    if (cpu_req) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cpu_req) begin
                        state <= SETUP;
                    end else begin
                        shadow <= new_map;
                        if (scan_row == 3'd7 && scan_col == 3'd7) begin
                            key_map     <= new_map;
                            map_valid   <= 1'b1;
                            map_changed <= (new_map != key_map);
                            scan_row    <= '0;
                            scan_col    <= '0;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            if (scan_col == 3'd7) scan_row <= scan_row + 3'd1;
                            scan_col <= scan_col + 3'd1;
                            state    <= SETUP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(SCAN_GAP)) begin
                        gap_cnt <= '0;
                        state   <= scan_en ? SETUP : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/kbd_matrix_arb.sv
// Shares the keyboard matrix lookup between the CPU (priority) and the scanner.
module kbd_matrix_arb
    import kbd_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned SCAN_GAP = 1024
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               scan_en,
    input  logic               cpu_req,
    input  logic [2:0]         cpu_row,
    input  logic [7:0]         cpu_col,
    output logic               cpu_gnt,
    output logic               cpu_hit,
    output logic [2:0]         kb_row,
    output logic [7:0]         kb_col,
    input  logic               kb_hit,
    output logic [KB_KEYS-1:0] key_map,
    output logic               map_valid,
    output logic               map_changed,
    output logic               any_key
);

    logic [2:0] scan_row;
    logic [2:0] scan_col;

    kbd_scan_seq #(
        .SETTLE   (SETTLE),
        .SCAN_GAP (SCAN_GAP)
    ) u_seq (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .cpu_req     (cpu_req),
        .kb_hit      (kb_hit),
        .scan_row    (scan_row),
        .scan_col    (scan_col),
        .key_map     (key_map),
        .map_valid   (map_valid),
        .map_changed (map_changed)
    );

    assign cpu_gnt = cpu_req;
    assign cpu_hit = cpu_req & kb_hit;
    assign kb_row  = cpu_req ? cpu_row : scan_row;
    assign kb_col  = cpu_req ? cpu_col : ~(8'h01 << scan_col);
    assign any_key = |key_map;

endmodule

// File: tb/tb_kbd_matrix_arb.sv
// Bench for kbd_matrix_arb: matrix model, scan reference model, vector table and corner sequences.
module tb_kbd_matrix_arb;

    localparam int SETTLE   = 2;
    localparam int SCAN_GAP = 1024;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic        cpu_req;
    logic [2:0]  cpu_row;
    logic [7:0]  cpu_col;
    logic        cpu_gnt, cpu_hit;
    logic [2:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_hit = 1'b0;
    logic [63:0] key_map;
    logic        map_valid, map_changed, any_key;

    logic [63:0] pressed;
    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    kbd_matrix_arb #(.SETTLE(SETTLE), .SCAN_GAP(SCAN_GAP)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .cpu_req     (cpu_req),
        .cpu_row     (cpu_row),
        .cpu_col     (cpu_col),
        .cpu_gnt     (cpu_gnt),
        .cpu_hit     (cpu_hit),
        .kb_row      (kb_row),
        .kb_col      (kb_col),
        .kb_hit      (kb_hit),
        .key_map     (key_map),
        .map_valid   (map_valid),
        .map_changed (map_changed),
        .any_key     (any_key)
    );

    // Matrix: registered lookup, hit when every low column bit has its key pressed.
    function automatic logic hitfn(input logic [2:0] r, input logic [7:0] c);
        logic [7:0] pr;
        pr = pressed[{r, 3'b000} +: 8];
        return &(pr | c);
    endfunction

    always @(posedge clk_sys) kb_hit <= hitfn(kb_row, kb_col);

    // Reference: each key needs SETTLE+1 consecutive CPU-free cycles; a CPU cycle loses progress on that key.
    logic [63:0] m_acc, m_map;
    logic        m_pulse, m_chg, m_busy;
    int          m_done, m_run, m_gap;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0; m_map <= '0; m_pulse <= 1'b0; m_chg <= 1'b0;
            m_busy <= 1'b0; m_done <= 0; m_run <= 0; m_gap <= 0;
        end else begin
            m_pulse <= 1'b0;
            m_chg   <= 1'b0;
            if (m_busy) begin
                if (cpu_req) m_run <= 0;
                else if (m_run == SETTLE) begin
                    m_acc[m_done] <= pressed[m_done];
                    m_done <= m_done + 1;
                    m_run  <= 0;
                    if (m_done == 63) begin
                        m_busy  <= 1'b0;
                        m_pulse <= 1'b1;
                        m_gap   <= SCAN_GAP + 1;
                        m_map   <= {pressed[63], m_acc[62:0]};
                        m_chg   <= ({pressed[63], m_acc[62:0]} != m_map);
                    end
                end else m_run <= m_run + 1;
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
                if (m_gap == 1 && scan_en) begin
                    m_busy <= 1'b1; m_done <= 0; m_run <= 0;
                end
            end else if (scan_en && !cpu_req) begin
                m_busy <= 1'b1; m_done <= 0; m_run <= 0;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (rst_n === 1'b1) begin
            total++;
            if (map_valid !== m_pulse || key_map !== m_map || map_changed !== m_chg ||
                any_key !== (m_map != 64'd0)) begin
                bad++;
                $display("FAIL model_cmp t=%0t: valid=%b chg=%b any=%b map=%h want valid=%b chg=%b map=%h",
                         $time, map_valid, map_changed, any_key, key_map, m_pulse, m_chg, m_map);
            end
            total++;
            if (cpu_hit !== (cpu_req ? hitfn(cpu_row, cpu_col) : 1'b0)) begin
                bad++;
                $display("FAIL cpu_hit t=%0t: got %b want %b", $time, cpu_hit,
                         cpu_req ? hitfn(cpu_row, cpu_col) : 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(output int n);
        n = -1;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (map_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic restart();
        rst_n = 1'b0; scan_en = 1'b0; cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       req;
        logic [2:0] row;
        logic [7:0] col;
        logic [2:0] e_row;
        logic [7:0] e_col;
        logic       e_gnt;
        logic       e_hit;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int burst;
        int pulses;
        bit got;

        // Pressed keys for the table: (0,0) and (4,0). Scanner idles at (0,0).
        tbl[0] = '{1'b0, 3'd4, 8'hFE, 3'd0, 8'hFE, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 3'd4, 8'hFE, 3'd4, 8'hFE, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 3'd4, 8'hFC, 3'd4, 8'hFC, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 3'd3, 8'hFE, 3'd3, 8'hFE, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 3'd4, 8'h7F, 3'd4, 8'h7F, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 3'd0, 8'hFE, 3'd0, 8'hFE, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 3'd7, 8'h00, 3'd0, 8'hFE, 1'b0, 1'b0};

        rst_n = 1'b0; scan_en = 1'b0; cpu_req = 1'b0; cpu_row = '0; cpu_col = 8'hFF;
        pressed = 64'h0000_0001_0000_0001;
        repeat (3) tick();
        chk("rst_key_map", key_map, 64'd0);
        chk("rst_map_valid", {63'd0, map_valid}, 64'd0);
        chk("rst_map_changed", {63'd0, map_changed}, 64'd0);
        chk("rst_any_key", {63'd0, any_key}, 64'd0);
        chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("rst_kb_row", {61'd0, kb_row}, 64'd0);
        chk("rst_kb_col", {56'd0, kb_col}, 64'hFE);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            cpu_req = tbl[i].req; cpu_row = tbl[i].row; cpu_col = tbl[i].col;
            #1;
            chk($sformatf("vec%0d_kb_row", i), {61'd0, kb_row}, {61'd0, tbl[i].e_row});
            chk($sformatf("vec%0d_kb_col", i), {56'd0, kb_col}, {56'd0, tbl[i].e_col});
            chk($sformatf("vec%0d_cpu_gnt", i), {63'd0, cpu_gnt}, {63'd0, tbl[i].e_gnt});
            tick();
            chk($sformatf("vec%0d_cpu_hit", i), {63'd0, cpu_hit}, {63'd0, tbl[i].e_hit});
        end
        cpu_req = 1'b0;
        pressed = 64'h0000_0001_0000_0000;
        tick();

        // Two uninterrupted scans with only (4,0) pressed.
        scan_en = 1'b1;
        wait_pulse(n);
        chk("scan1_latency", n, 193);
        chk("scan1_key_map", key_map, 64'h0000_0001_0000_0000);
        chk("scan1_any_key", {63'd0, any_key}, 64'd1);
        chk("scan1_changed", {63'd0, map_changed}, 64'd1);
        wait_pulse(n);
        chk("scan2_period", n, 1217);
        chk("scan2_changed", {63'd0, map_changed}, 64'd0);

        // CPU takes the matrix for 10 cycles starting at the SAMPLE cycle of (2,5).
        restart();
        pressed = 64'h0400_0001_0000_0000;
        scan_en = 1'b1;
        repeat (66) tick();
        cpu_req = 1'b1; cpu_row = 3'd7; cpu_col = 8'hFB;
        #1;
        chk("pre_kb_row", {61'd0, kb_row}, 64'd7);
        chk("pre_kb_col", {56'd0, kb_col}, 64'hFB);
        chk("pre_cpu_gnt", {63'd0, cpu_gnt}, 64'd1);
        tick();
        chk("pre_cpu_hit", {63'd0, cpu_hit}, 64'd1);
        repeat (9) tick();
        cpu_req = 1'b0;
        #1;
        chk("pre_cpu_hit_off", {63'd0, cpu_hit}, 64'd0);
        wait_pulse(n);
        chk("pre_latency", (n < 0) ? -1 : n + 76, 193 + 10 + SETTLE);
        chk("pre_key_map", key_map, 64'h0400_0001_0000_0000);

        // One-cycle CPU pulse on the SAMPLE cycle of (1,2).
        restart();
        pressed = 64'h0000_0000_0000_0400;
        scan_en = 1'b1;
        repeat (33) tick();
        cpu_req = 1'b1; cpu_row = 3'd0; cpu_col = 8'hFF;
        tick();
        cpu_req = 1'b0;
        wait_pulse(n);
        chk("blip_latency", (n < 0) ? -1 : n + 34, 196);
        chk("blip_key_map", key_map, 64'h0000_0000_0000_0400);

        // scan_en dropped at (3,3): scan still publishes, then no further scans.
        restart();
        pressed = 64'h8000_0000_0000_0081;
        scan_en = 1'b1;
        repeat (82) tick();
        scan_en = 1'b0;
        wait_pulse(n);
        chk("drop_latency", (n < 0) ? -1 : n + 82, 193);
        chk("drop_key_map", key_map, 64'h8000_0000_0000_0081);
        pulses = 0;
        repeat (1400) begin
            tick();
            if (map_valid) pulses++;
        end
        chk("drop_no_pulse", pulses, 0);

        // Reset at (6,1) with a published map present.
        scan_en = 1'b1;
        repeat (148) tick();
        chk("pos61_kb_row", {61'd0, kb_row}, 64'd6);
        chk("pos61_kb_col", {56'd0, kb_col}, 64'hFD);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_key_map", key_map, 64'd0);
        chk("arst_any_key", {63'd0, any_key}, 64'd0);
        chk("arst_kb_row", {61'd0, kb_row}, 64'd0);
        chk("arst_kb_col", {56'd0, kb_col}, 64'hFE);
        tick();
        rst_n = 1'b1;
        wait_pulse(n);
        chk("arst_restart_latency", n, 193);
        chk("arst_key_map2", key_map, 64'h8000_0000_0000_0081);
        chk("arst_changed", {63'd0, map_changed}, 64'd1);

        // Random maps and random CPU bursts; the reference model checks every cycle.
        burst = 0;
        for (int s = 0; s < 6; s++) begin
            pressed = {$urandom, $urandom};
            got = 1'b0;
            for (int c = 0; c < 3000 && !got; c++) begin
                if (burst > 0) burst--;
                else if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 6);
                cpu_req = (burst > 0);
                cpu_row = 3'($urandom);
                cpu_col = 8'($urandom);
                tick();
                if (map_valid) got = 1'b1;
            end
            chk($sformatf("rnd%0d_published", s), {63'd0, got}, 64'd1);
            chk($sformatf("rnd%0d_key_map", s), key_map, pressed);
        end
        cpu_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_matrix_arb.md
# kbd_matrix_arb

Arbiter and autonomous scanner for the 8×8 keyboard matrix lookup in the Oric core. It shares the matrix lookup port (row, column mask, hit) between two requesters:
- the CPU path (VIA port B row select, PSG column mask), which always has priority;
- an internal scanner that walks all 64 keys and publishes a registered key bitmap. OSD and hotkey logic use this bitmap.

## Interface
Parameters:
- SETTLE, 2: cycles the scanner holds row/col before sampling; must be ≥2 (the matrix registers its row lookup once)
- SCAN_GAP, 1024: idle cycles between completed scans; 0 means back-to-back scans

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- scan_en  in  1  allow the scanner to start new scans
- cpu_req  in  1  CPU owns the matrix while high
- cpu_row  in  3  CPU row select
- cpu_col  in  8  CPU column mask, active-low select
- cpu_gnt  out  1  equals cpu_req (combinational)
- cpu_hit  out  1  kb_hit while cpu_req is high, else 0
- kb_row  out  3  row to matrix
- kb_col  out  8  column mask to matrix
- kb_hit  in  1  matrix result; 1 when every selected column key is pressed
- key_map  out  64  bit row*8+c is 1 when key (row,c) is pressed
- map_valid  out  1  one-cycle pulse when key_map updates
- map_changed  out  1  one-cycle pulse, coincident with map_valid, when the new map differs from the previous one
- any_key  out  1  OR of key_map

## Operation
- Mux:
  - cpu_req=1: kb_row=cpu_row, kb_col=cpu_col, combinational, same cycle.
  - Otherwise: kb_row=scan row, kb_col=~(8'h01<<scan col).
- Scanner FSM states: IDLE, SETUP, SAMPLE, GAP.
  - IDLE: go to SETUP at position (0,0) when scan_en=1 and cpu_req=0.
  - SETUP: drive the position; count SETTLE cycles; then go to SAMPLE.
  - SAMPLE: write kb_hit into the shadow bit row*8+col.
    - If not the last position: advance col, wrapping 7→0 with row+1, and go to SETUP.
    - At position (7,7): copy shadow into key_map, pulse map_valid, compare for map_changed, then go to GAP.
  - GAP: count SCAN_GAP cycles. At the end, go to SETUP (0,0) if scan_en=1, else go to IDLE.
- Preemption: cpu_req=1 in SETUP or SAMPLE freezes the FSM. No sample is written, including when cpu_req rises in the SAMPLE cycle itself. When cpu_req falls, restart SETUP at the same position with a full SETTLE count.
- cpu_req has no effect in GAP or IDLE, except that it holds IDLE.
- scan_en=0 mid-scan does not abort the scan. The current scan completes and publishes, then the FSM goes to IDLE after GAP.
- key_map only changes on publish. A partial scan never reaches key_map.

## Timing
- Reset values: key_map=0, shadow=0, map_valid=0, map_changed=0, any_key=0. FSM in IDLE, position (0,0), counters 0. cpu_gnt and cpu_hit follow their inputs, with cpu_hit=0 when cpu_req=0.
- Reset asserted mid-scan: immediate return to the reset state; no publish.
- CPU latency: kb_row/kb_col switch in the cycle cpu_req rises. cpu_hit is valid from the second cycle of cpu_req (the matrix has one register stage).
- Uninterrupted scan: 64×(SETTLE+1) cycles, i.e. 192 with defaults.
- Publish and pulse timing: map_valid rises the cycle after the (7,7) SAMPLE. any_key updates in the same cycle.
- Scan period: scan-start to next scan-start is 64×(SETTLE+1)+1+SCAN_GAP cycles.

## Structure
- Shared kbd_pkg holds:
  - the scan state enum (IDLE/SETUP/SAMPLE/GAP);
  - KB_ROWS=8, KB_COLS=8, KB_KEYS=64;
  - the function key_idx(row,col)=row*8+col.
- Sub-module kbd_scan_seq holds the FSM, settle/gap counters, position, shadow and publish logic. The top level holds the ownership mux and cpu_hit gating.

## Test plan
- Reset, scan_en=1, matrix model with only (4,0) pressed, defaults → after 193 cycles map_valid pulses once; key_map=64'h0000_0001_0000_0000; any_key=1; map_changed=1.
- Same stimulus, second scan → map_valid pulses again 1217 cycles after the first; map_changed=0.
- cpu_req high for 10 cycles during position (2,5), cpu_row=7, cpu_col=8'hFB with (7,2) pressed → kb_row=7 and kb_col=8'hFB in the first cycle; cpu_hit=1 from cycle 2; the scan completes 10+SETTLE cycles later than nominal; key_map is correct.
- cpu_req pulse of one cycle exactly at a SAMPLE cycle → that sample is discarded; position is re-set up; the final key_map matches the model.
- scan_en dropped at position (3,3) → the scan publishes, the FSM enters GAP then IDLE, and no further map_valid occurs.
- rst_n asserted at position (6,1) after a prior map with keys set → all outputs return to 0 asynchronously; after release the scan restarts at (0,0).
